mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-ported, variable-latency memory between instruction fetch (IF) and data access (DM) of the pipelined RV32I core.
// - Sits between the fetch/MEM pipeline stages and the unified memory; one transaction outstanding at a time.
// - DM has priority to drain the pipeline; a streak limit prevents fetch starvation; a timeout guards against a hung memory.
// PARAMETERS
// - MAX_D_STREAK  4    consecutive DM grants allowed while if_req is pending; 1..15
// - TIMEOUT_CYC   255  cycles in a BUSY state without mem_ready before abort; 1..255
// PORTS
// - clk         in   1   single clock, rising edge
// - rst         in   1   synchronous, active-high reset
// - if_req      in   1   fetch request; held with if_addr stable until if_ack
// - if_addr     in   32  fetch byte address (word aligned)
// - if_rdata    out  32  fetched instruction; valid with if_ack, held until next if_ack
// - if_ack      out  1   one-cycle completion pulse to fetch
// - dm_req      in   1   data request; held with dm_* stable until dm_ack
// - dm_we       in   1   1 = store, 0 = load
// - dm_func3    in   3   RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
// - dm_addr     in   32  data byte address
// - dm_wdata    in   32  store data
// - dm_rdata    out  32  load data; valid with dm_ack, held until next dm_ack
// - dm_ack      out  1   one-cycle completion pulse to data stage
// - bus_err     out  1   pulses with if_ack/dm_ack when that transaction timed out
// - mem_req     out  1   memory request, high for the whole BUSY state
// - mem_we      out  1   write enable; always 0 for IF transactions
// - mem_func3   out  3   width code; 3'b010 (word) for IF transactions
// - mem_addr    out  32  latched address
// - mem_wdata   out  32  latched store data; 0 for IF transactions
// - mem_rdata   in   32  memory read data, sampled in the mem_ready cycle
// - mem_ready   in   1   one-cycle completion from memory; may come in the first mem_req cycle
// - owner       out  2   debug: 00 none, 01 IF, 10 DM
// BEHAVIOUR
// - Reset (rst=1 at an edge): state IDLE; mem_req, mem_we, if_ack, dm_ack, bus_err = 0; mem_func3, mem_addr, mem_wdata, if_rdata, dm_rdata = 0; owner = 00; streak and timeout counters = 0.
// - Reset mid-transaction: mem_req drops at that edge; no ack is generated; any later mem_ready is ignored in IDLE.
// - FSM (registered, Moore outputs): IDLE, BUSY_I, BUSY_D, DONE.
// - IDLE: sample requests, latch the winner's address/data/we/func3 into the mem_* registers, go to BUSY_I/BUSY_D. No request: stay IDLE.
// - Arbitration: only dm_req -> DM; only if_req -> IF; both -> DM, unless streak == MAX_D_STREAK, then IF.
// - Streak counter: +1 on each DM grant while if_req = 1; cleared on an IF grant, or when if_req = 0 at arbitration; saturates.
// - BUSY_x: mem_req = 1 and owner = x. On mem_ready: latch mem_rdata into x_rdata (IF always; DM on load only), go to DONE.
// - Timeout counter: cleared on entry to BUSY; +1 per BUSY cycle without mem_ready. At TIMEOUT_CYC: go to DONE with bus_err set; rdata = 32'h0000_0013 for IF (NOP), unchanged for DM.
// - DONE: exactly one of if_ack/dm_ack = 1 for this single cycle, bus_err if flagged; mem_req = 0; requests ignored; next state IDLE.
// - A req still high in the cycle after ack is a new transaction.
// - Minimum latency, zero-wait memory: req seen at edge t -> mem_req in [t,t+1) -> ready -> ack in [t+1,t+2) -> IDLE at t+2.
// - Each transaction takes at least 3 cycles.
// - mem_ready outside BUSY is ignored. Changing x_req, x_addr or x_wdata before the ack is illegal; the latched copy is used.
// STRUCTURE
// - Shared defines.v: ARB_IDLE/ARB_BUSY_I/ARB_BUSY_D/ARB_DONE (2-bit), ARB_OWNER_NONE/IF/DM, NOP constant 32'h0000_0013, func3 word 3'b010.
// - One FSM always-block plus register blocks. The address, data and rdata latches use the existing NBitRegister #(32).
// - No new sub-module.
// TESTING
// - Single fetch, mem_ready in first BUSY cycle, addr 0x40, rdata 0x00500093 -> if_ack 2 cycles after req edge, if_rdata = 0x00500093, mem_we = 0, mem_func3 = 010.
// - Simultaneous if_req and dm_req (SW 0xDEADBEEF to 0x100, func3 010) -> DM served first (mem_we = 1, mem_wdata = 0xDEADBEEF), then IF; acks in that order.
// - dm_req held high with back-to-back loads, if_req pending, MAX_D_STREAK = 4 -> exactly 4 dm_acks, then one if_ack, then DM resumes.
// - mem_ready never asserted, TIMEOUT_CYC = 8 on a fetch -> if_ack and bus_err pulse together; if_rdata = 0x00000013; FSM back to IDLE.
// - rst asserted during BUSY_D with a mem_ready 2 cycles later -> mem_req 0 after the rst edge; no dm_ack; all outputs at reset values; next dm_req served normally.
// - LBU from 0x203, mem_rdata 0x000000AB after 3 wait cycles -> mem_func3 = 100, mem_addr = 0x203, dm_rdata = 0x000000AB, dm_ack 1 cycle after mem_ready.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/DM memory port arbiter.
// State codes, owner codes and fixed fetch constants.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_BUSY_I = 2'b01,
        ARB_BUSY_D = 2'b10,
        ARB_DONE   = 2'b11
    } arbState_t;

    localparam logic [1:0] ARB_OWNER_NONE = 2'b00;
    localparam logic [1:0] ARB_OWNER_IF   = 2'b01;
    localparam logic [1:0] ARB_OWNER_DM   = 2'b10;

    localparam logic [31:0] ARB_NOP    = 32'h0000_0013;
    localparam logic [2:0]  FUNC3_WORD = 3'b010;

endpackage

// File: rtl/NBitRegister.sv
// Generic enabled register with synchronous active-high reset.
// Used for the arbiter's address, data and read-data latches.
module NBitRegister #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Load d when enabled; clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and data access.
// DM wins ties until its streak limit; a timeout aborts hung accesses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [2:0]  dm_func3,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_func3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  owner
);

    localparam logic [3:0] StreakMax = 4'(MAX_D_STREAK);
    localparam logic [7:0] TmoLast   = 8'(TIMEOUT_CYC - 1);

    arbState_t   state;
    arbState_t   nextState;
    logic [3:0]  streak;
    logic [3:0]  streakNext;
    logic [7:0]  tmoCnt;
    logic [7:0]  tmoNext;
    logic        errFlag;
    logic        errNext;
    logic        ownerD;
    logic        ownerDNext;
    logic        memWe;
    logic        memWeNext;
    logic [2:0]  memFunc3;
    logic [2:0]  memFunc3Next;
    logic        latchReq;
    logic [31:0] addrD;
    logic [31:0] wdataD;
    logic        ifLoad;
    logic        dmLoad;
    logic [31:0] ifRdataD;

    // Next-state, arbitration, streak and timeout decisions.
    always_comb begin
        nextState    = state;
        streakNext   = streak;
        tmoNext      = tmoCnt;
        errNext      = errFlag;
        ownerDNext   = ownerD;
        memWeNext    = memWe;
        memFunc3Next = memFunc3;
        latchReq     = 1'b0;
        addrD        = mem_addr;
        wdataD       = mem_wdata;
        ifLoad       = 1'b0;
        dmLoad       = 1'b0;
        ifRdataD     = mem_rdata;
        unique case (state)
            ARB_IDLE: begin
                if (dm_req || if_req) begin
                    latchReq = 1'b1;
                    tmoNext  = 8'd0;
                    errNext  = 1'b0;
                    if (dm_req && !(if_req && streak == StreakMax)) begin
                        nextState    = ARB_BUSY_D;
                        ownerDNext   = 1'b1;
                        memWeNext    = dm_we;
                        memFunc3Next = dm_func3;
                        addrD        = dm_addr;
                        wdataD       = dm_wdata;
                        if (!if_req) begin
                            streakNext = 4'd0;
                        end else if (streak != 4'hF) begin
                            streakNext = streak + 4'd1;
                        end
                    end else begin
                        nextState    = ARB_BUSY_I;
                        ownerDNext   = 1'b0;
                        memWeNext    = 1'b0;
                        memFunc3Next = FUNC3_WORD;
                        addrD        = if_addr;
                        wdataD       = 32'd0;
                        streakNext   = 4'd0;
                    end
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (mem_ready) begin
                    nextState = ARB_DONE;
                    ifLoad    = !ownerD;
                    dmLoad    = ownerD && !memWe;
                end else if (tmoCnt == TmoLast) begin
                    nextState = ARB_DONE;
                    errNext   = 1'b1;
                    tmoNext   = tmoCnt + 8'd1;
                    ifLoad    = !ownerD;
                    ifRdataD  = ARB_NOP;
                end else begin
                    tmoNext = tmoCnt + 8'd1;
                end
            end
            ARB_DONE: begin
                nextState = ARB_IDLE;
            end
            default: begin
                nextState = ARB_IDLE;
            end
        endcase
    end

    // State and small control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            streak   <= 4'd0;
            tmoCnt   <= 8'd0;
            errFlag  <= 1'b0;
            ownerD   <= 1'b0;
            memWe    <= 1'b0;
            memFunc3 <= 3'd0;
        end else begin
            state    <= nextState;
            streak   <= streakNext;
            tmoCnt   <= tmoNext;
            errFlag  <= errNext;
            ownerD   <= ownerDNext;
            memWe    <= memWeNext;
            memFunc3 <= memFunc3Next;
        end
    end

    NBitRegister #(.N(32)) addrReg (
        .clk (clk),
        .rst (rst),
        .en  (latchReq),
        .d   (addrD),
        .q   (mem_addr)
    );

    NBitRegister #(.N(32)) wdataReg (
        .clk (clk),
        .rst (rst),
        .en  (latchReq),
        .d   (wdataD),
        .q   (mem_wdata)
    );

    NBitRegister #(.N(32)) ifRdataReg (
        .clk (clk),
        .rst (rst),
        .en  (ifLoad),
        .d   (ifRdataD),
        .q   (if_rdata)
    );

    NBitRegister #(.N(32)) dmRdataReg (
        .clk (clk),
        .rst (rst),
        .en  (dmLoad),
        .d   (mem_rdata),
        .q   (dm_rdata)
    );

    assign mem_req   = (state == ARB_BUSY_I) || (state == ARB_BUSY_D);
    assign mem_we    = memWe;
    assign mem_func3 = memFunc3;
    assign if_ack    = (state == ARB_DONE) && !ownerD;
    assign dm_ack    = (state == ARB_DONE) && ownerD;
    assign bus_err   = (state == ARB_DONE) && errFlag;
    assign owner     = (state == ARB_BUSY_I) ? ARB_OWNER_IF :
                       (state == ARB_BUSY_D) ? ARB_OWNER_DM : ARB_OWNER_NONE;

endmodule
